// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: access state encoding and
// default memory-handshake constants.
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int          DEF_TIMEOUT  = 255;
   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards EX/MEM fields to MEM/WB and runs a req/ack
// handshake with a variable-latency data memory, stalling until it completes.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int          TIMEOUT  = DEF_TIMEOUT,
   parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        MemtoReg_i,
   input  logic        RegWrite_i,
   input  logic [31:0] ALUresult_i,
   input  logic [31:0] WriteData_i,
   input  logic [4:0]  RDaddr_i,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        MemtoReg_o,
   output logic        RegWrite_o,
   output logic [31:0] Memdata_o,
   output logic [31:0] ALUresult_o,
   output logic [4:0]  RDaddr_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic             we_q, err_q;
   logic             mem_op, start, ack_hit, timeout_hit, busy_stall;

   assign mem_op = MemRead_i | MemWrite_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start       = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      busy_stall  = 1'b0;
      mem_req_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               start      = 1'b1;
               busy_stall = 1'b1;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            busy_stall = 1'b1;
            mem_req_o  = 1'b1;
            if (mem_ack_i) begin
               ack_hit = 1'b1;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request registers, wait counter and returned data
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (start) begin
            // A simultaneous read+write is treated as a store.
            addr_q  <= {ALUresult_i[31:2], 2'b00};
            wdata_q <= WriteData_i;
            we_q    <= MemWrite_i;
            cnt_q   <= '0;
            if (ALUresult_i[1:0] != 2'b00) err_q <= 1'b1;
         end else if (state_q == BUSY && !ack_hit && !timeout_hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (ack_hit && !we_q) rdata_q <= mem_rdata_i;
         if (timeout_hit) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
         end
      end
   end

   // Stall is gated by reset so it drops the moment reset asserts.
   assign stall_o     = busy_stall & rst_n_i;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign RegWrite_o  = RegWrite_i & ~stall_o;
   assign MemtoReg_o  = MemtoReg_i;
   assign ALUresult_o = ALUresult_i;
   assign RDaddr_o    = RDaddr_i;
   assign Memdata_o   = (state_q == DONE) ? rdata_q : 32'h0;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of pass-through vectors plus
// hand-written load/store/timeout/misalign/reset sequences.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite, MemtoReg, RegWrite;
   logic [31:0] ALUresult, WriteData, rdata;
   logic [4:0]  RDaddr;
   logic        ack;
   logic        ack_none;

   logic        mem_req, mem_we, MemtoReg_o, RegWrite_o, stall, err;
   logic [31:0] mem_addr, mem_wdata, Memdata, ALUresult_o;
   logic [4:0]  RDaddr_o;

   logic        t4_req, t4_we, t4_m2r, t4_rw, t4_stall, t4_err;
   logic [31:0] t4_addr, t4_wdata, t4_memdata, t4_alu;
   logic [4:0]  t4_rd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .MemRead_i(MemRead), .MemWrite_i(MemWrite), .MemtoReg_i(MemtoReg),
      .RegWrite_i(RegWrite), .ALUresult_i(ALUresult), .WriteData_i(WriteData),
      .RDaddr_i(RDaddr), .mem_ack_i(ack), .mem_rdata_i(rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
      .Memdata_o(Memdata), .ALUresult_o(ALUresult_o), .RDaddr_o(RDaddr_o),
      .stall_o(stall), .err_o(err)
   );

   mem_access_stage #(.TIMEOUT(4)) dut_t4 (
      .clk_i(clk), .rst_n_i(rst_n),
      .MemRead_i(MemRead), .MemWrite_i(MemWrite), .MemtoReg_i(MemtoReg),
      .RegWrite_i(RegWrite), .ALUresult_i(ALUresult), .WriteData_i(WriteData),
      .RDaddr_i(RDaddr), .mem_ack_i(ack_none), .mem_rdata_i(rdata),
      .mem_req_o(t4_req), .mem_we_o(t4_we), .mem_addr_o(t4_addr),
      .mem_wdata_o(t4_wdata), .MemtoReg_o(t4_m2r), .RegWrite_o(t4_rw),
      .Memdata_o(t4_memdata), .ALUresult_o(t4_alu), .RDaddr_o(t4_rd),
      .stall_o(t4_stall), .err_o(t4_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic noop();
      MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
      ALUresult = 0; WriteData = 0; RDaddr = 0; ack = 0; rdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      noop();
      rst_n = 0;
      #2;
      rst_n = 1;
   endtask

   typedef struct {
      logic        mr, mw, m2r, rw;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        exp_stall, exp_rw;
   } vec_t;

   vec_t vecs[5];

   int stalls, k;
   logic rw_seen, steady, done_seen;

   initial begin
      ack_none = 0;
      noop();
      rst_n = 0;

      vecs[0] = '{mr:0, mw:0, m2r:0, rw:1, alu:32'h0000_1234, rd:5'd5,  exp_stall:0, exp_rw:1};
      vecs[1] = '{mr:0, mw:0, m2r:1, rw:0, alu:32'hFFFF_FFFF, rd:5'd31, exp_stall:0, exp_rw:0};
      vecs[2] = '{mr:1, mw:0, m2r:1, rw:1, alu:32'h0000_0010, rd:5'd3,  exp_stall:1, exp_rw:0};
      vecs[3] = '{mr:1, mw:1, m2r:0, rw:1, alu:32'h0000_0020, rd:5'd9,  exp_stall:1, exp_rw:0};
      vecs[4] = '{mr:0, mw:0, m2r:0, rw:1, alu:32'h8000_0000, rd:5'd0,  exp_stall:0, exp_rw:1};

      // Reset state
      #3;
      chk("rst_req", mem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_err", err, 0);
      chk("rst_memdata", Memdata, 0);
      @(negedge clk);
      rst_n = 1;

      // Table: single-cycle pass-through, op cycles withdrawn before the edge
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         MemRead = vecs[i].mr; MemWrite = vecs[i].mw; MemtoReg = vecs[i].m2r;
         RegWrite = vecs[i].rw; ALUresult = vecs[i].alu; RDaddr = vecs[i].rd;
         #1;
         chk($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
         chk($sformatf("v%0d_rw", i), RegWrite_o, vecs[i].exp_rw);
         chk($sformatf("v%0d_alu", i), ALUresult_o, vecs[i].alu);
         chk($sformatf("v%0d_rd", i), RDaddr_o, vecs[i].rd);
         chk($sformatf("v%0d_m2r", i), MemtoReg_o, vecs[i].m2r);
         chk($sformatf("v%0d_memdata", i), Memdata, 0);
         chk($sformatf("v%0d_req", i), mem_req, 0);
         #1;
         noop();
      end

      // Load at 0x100, ack in the first request cycle
      @(negedge clk);
      MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUresult = 32'h100; RDaddr = 5'd7;
      #1;
      chk("ld_t_stall", stall, 1);
      chk("ld_t_rw", RegWrite_o, 0);
      chk("ld_t_req", mem_req, 0);
      @(negedge clk);
      ack = 1; rdata = 32'hCAFE_F00D;
      #1;
      chk("ld_t1_req", mem_req, 1);
      chk("ld_t1_addr", mem_addr, 32'h100);
      chk("ld_t1_we", mem_we, 0);
      chk("ld_t1_stall", stall, 1);
      chk("ld_t1_rw", RegWrite_o, 0);
      @(negedge clk);
      ack = 0; rdata = 0;
      #1;
      chk("ld_done_stall", stall, 0);
      chk("ld_done_req", mem_req, 0);
      chk("ld_done_data", Memdata, 32'hCAFE_F00D);
      chk("ld_done_rd", RDaddr_o, 7);
      chk("ld_done_rw", RegWrite_o, 1);
      @(negedge clk);
      noop();
      #1;
      chk("ld_after_stall", stall, 0);
      chk("ld_after_data", Memdata, 0);

      // Store at 0x204, ack on the fifth request cycle
      @(negedge clk);
      MemWrite = 1; ALUresult = 32'h204; WriteData = 32'h55AA;
      stalls = 0; rw_seen = 0; steady = 1; done_seen = 0;
      #1;
      if (stall) stalls++;
      if (RegWrite_o) rw_seen = 1;
      for (k = 1; k < 20 && !done_seen; k++) begin
         @(negedge clk);
         ack = (k == 5);
         #1;
         if (stall) stalls++; else done_seen = 1;
         if (RegWrite_o) rw_seen = 1;
         if (k <= 5 && !(mem_req && mem_we && mem_wdata == 32'h55AA && mem_addr == 32'h204))
            steady = 0;
      end
      chk("st_done_seen", done_seen, 1);
      chk("st_stall_cycles", stalls, 6);
      chk("st_rw_low", rw_seen, 0);
      chk("st_req_steady", steady, 1);
      chk("st_no_err", err, 0);
      @(negedge clk);
      noop();

      // Misaligned load at 0x103
      @(negedge clk);
      MemRead = 1; RegWrite = 1; ALUresult = 32'h103;
      @(negedge clk);
      ack = 1; rdata = 32'h1111_2222;
      #1;
      chk("mis_addr", mem_addr, 32'h100);
      chk("mis_err", err, 1);
      @(negedge clk);
      ack = 0;
      #1;
      chk("mis_data", Memdata, 32'h1111_2222);
      @(negedge clk);
      noop();

      // Timeout on the TIMEOUT=4 instance: DONE 4 cycles after BUSY entry
      do_reset();
      #1;
      chk("t4_err_cleared", t4_err, 0);
      @(negedge clk);
      MemRead = 1; RegWrite = 1; ALUresult = 32'h300;
      done_seen = 0; stalls = 0;
      for (k = 1; k < 20 && !done_seen; k++) begin
         @(negedge clk);
         #1;
         if (!t4_stall) begin
            done_seen = 1;
            stalls = k;
            chk("to_memdata", t4_memdata, 32'hDEAD_BEEF);
            chk("to_err", t4_err, 1);
         end
      end
      chk("to_done_cycle", stalls, 5);
      @(negedge clk);
      noop();
      repeat (3) @(negedge clk);
      #1;
      chk("to_err_sticky", t4_err, 1);

      // Reset pulsed mid-BUSY, later ack ignored
      do_reset();
      @(negedge clk);
      MemRead = 1; ALUresult = 32'h40; RegWrite = 1;
      @(negedge clk);
      #1;
      chk("rb_req_before", mem_req, 1);
      rst_n = 0;
      #1;
      chk("rb_req_drop", mem_req, 0);
      chk("rb_stall_drop", stall, 0);
      chk("rb_alu_pass", ALUresult_o, 32'h40);
      @(negedge clk);
      noop();
      rst_n = 1;
      @(negedge clk);
      ack = 1; rdata = 32'h9999_9999;
      #1;
      chk("rb_ack_req", mem_req, 0);
      chk("rb_ack_stall", stall, 0);
      @(negedge clk);
      ack = 0;
      #1;
      chk("rb_idle_data", Memdata, 0);
      chk("rb_idle_stall", stall, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
